// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes pwm_in and measures period (rise to rise) and
// high time (rise to fall) of each complete cycle, in clk cycles.
//
// state | meaning
// IDLE  | disabled, counter cleared
// ARM   | waiting for the first rise; partial cycle at enable is discarded
// HIGH  | input high, counting toward the fall
// LOW   | input low, counting toward the closing rise
module pwm_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pwm_in,
    output logic        pwm_level,
    output logic [15:0] period_meas,
    output logic [15:0] high_meas,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;
    logic                   rise, fall, at_max;
    logic [15:0]            cnt_q, cnt_d, cnt_inc;
    logic [15:0]            high_cap_q, high_cap_d;
    logic [15:0]            period_d, high_d;
    logic                   valid_d, timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pwm_level = sync_q[SYNC_STAGES-1];
    assign rise      = pwm_level & ~delay_q;
    assign fall      = ~pwm_level & delay_q;
    assign at_max    = (cnt_q == 16'hFFFF);
    // Saturate so a 65535-cycle high phase still ends in a timeout, never a wrap.
    assign cnt_inc   = at_max ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_cap_d = high_cap_q;
        period_d   = period_meas;
        high_d     = high_meas;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = 16'd0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = 16'd1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d    = LOW;
                        high_cap_d = cnt_q;
                        cnt_d      = cnt_inc;
                    end else if (at_max) begin
                        state_d   = ARM;
                        cnt_d     = 16'd0;
                        period_d  = 16'd0;
                        high_d    = 16'd0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    // A full 65535-cycle high phase means the period already exceeds 16 bits.
                    if (rise && (high_cap_q != 16'hFFFF)) begin
                        state_d  = HIGH;
                        period_d = cnt_q;
                        high_d   = high_cap_q;
                        valid_d  = 1'b1;
                        cnt_d    = 16'd1;
                    end else if (rise || at_max) begin
                        state_d   = ARM;
                        cnt_d     = 16'd0;
                        period_d  = 16'd0;
                        high_d    = 16'd0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            high_cap_q  <= 16'd0;
            period_meas <= 16'd0;
            high_meas   <= 16'd0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_cap_q  <= high_cap_d;
            period_meas <= period_d;
            high_meas   <= high_d;
            valid       <= valid_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a background PWM source plus one task per
// scenario, each checking measured period/high time against hand-derived values.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pwm_in;
    logic        pwm_level;
    logic [15:0] period_meas;
    logic [15:0] high_meas;
    logic        valid;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    int gen_period = 10;
    int gen_high   = 3;
    int ph         = 0;
    bit gen_on     = 1'b0;
    bit gen_level  = 1'b0;

    always #5 clk = ~clk;

    pwm_capture #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .pwm_level   (pwm_level),
        .period_meas (period_meas),
        .high_meas   (high_meas),
        .valid       (valid),
        .timeout     (timeout)
    );

    // PWM source: changes 2 time units after each rising edge.
    initial begin
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (gen_on) begin
                pwm_in = (ph < gen_high);
                ph = (ph + 1 >= gen_period) ? 0 : ph + 1;
            end else begin
                pwm_in = gen_level;
            end
        end
    end

    task automatic restart(input int p, input int h);
        @(negedge clk);
        enable    = 1'b0;
        gen_on    = 1'b0;
        gen_level = 1'b0;
        repeat (8) @(negedge clk);
        gen_period = p;
        gen_high   = h;
        ph         = 0;
        gen_on     = 1'b1;
        enable     = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output int rises, output bit ok);
        bit prev;
        prev   = pwm_level;
        cycles = 0;
        rises  = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (pwm_level && !prev) rises++;
            prev = pwm_level;
            if (valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int seen;
        rst_n      = 1'b0;
        enable     = 1'b0;
        gen_period = 4;
        gen_high   = 2;
        ph         = 0;
        gen_on     = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (pwm_level !== 1'b0) begin bad++; $display("FAIL reset_level got=%0b want=0", pwm_level); end
        total++; if (period_meas !== 16'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", period_meas); end
        total++; if (high_meas !== 16'd0) begin bad++; $display("FAIL reset_high got=%0d want=0", high_meas); end
        total++; if ({valid, timeout} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {valid, timeout}); end
        rst_n = 1'b1;
        seen  = 0;
        repeat (1000) begin
            @(negedge clk);
            if (valid || timeout) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL idle_pulses got=%0d want=0", seen); end
    endtask

    task automatic test_steady();
        int c, r;
        bit ok;
        restart(10, 3);
        wait_valid(60, c, r, ok);
        total++; if (!ok) begin bad++; $display("FAIL steady_first got=none want=valid"); end
        total++; if (r != 2) begin bad++; $display("FAIL steady_first_rises got=%0d want=2", r); end
        total++; if (period_meas !== 16'd10 || high_meas !== 16'd3) begin
            bad++; $display("FAIL steady_first_vals got=%0d/%0d want=10/3", period_meas, high_meas);
        end
        for (int i = 0; i < 4; i++) begin
            wait_valid(60, c, r, ok);
            total++; if (!ok || c != 10) begin bad++; $display("FAIL steady_spacing got=%0d want=10", c); end
            total++; if (period_meas !== 16'd10 || high_meas !== 16'd3) begin
                bad++; $display("FAIL steady_vals got=%0d/%0d want=10/3", period_meas, high_meas);
            end
        end
    endtask

    task automatic test_min_period();
        int c, r;
        bit ok;
        restart(2, 1);
        wait_valid(60, c, r, ok);
        total++; if (!ok || period_meas !== 16'd2 || high_meas !== 16'd1) begin
            bad++; $display("FAIL min_first got=%0d/%0d want=2/1", period_meas, high_meas);
        end
        for (int i = 0; i < 4; i++) begin
            wait_valid(20, c, r, ok);
            total++; if (!ok || c != 2) begin bad++; $display("FAIL min_spacing got=%0d want=2", c); end
            total++; if (period_meas !== 16'd2 || high_meas !== 16'd1) begin
                bad++; $display("FAIL min_vals got=%0d/%0d want=2/1", period_meas, high_meas);
            end
        end
    endtask

    task automatic test_max_and_stuck();
        int c, r, k, nv;
        bit ok;
        restart(65535, 65534);
        wait_valid(70000, c, r, ok);
        total++; if (!ok) begin bad++; $display("FAIL max_valid got=none want=valid"); end
        total++; if (period_meas !== 16'd65535 || high_meas !== 16'd65534) begin
            bad++; $display("FAIL max_vals got=%0d/%0d want=65535/65534", period_meas, high_meas);
        end
        gen_on    = 1'b0;
        gen_level = 1'b1;
        k  = 0;
        nv = 0;
        while (k < 70000 && !timeout) begin
            @(negedge clk);
            k++;
            if (valid) nv++;
        end
        total++; if (!timeout || k != 65535) begin bad++; $display("FAIL stuck_timeout_delay got=%0d want=65535", k); end
        total++; if (nv != 0) begin bad++; $display("FAIL stuck_no_valid got=%0d want=0", nv); end
        total++; if (period_meas !== 16'd0 || high_meas !== 16'd0) begin
            bad++; $display("FAIL stuck_vals got=%0d/%0d want=0/0", period_meas, high_meas);
        end
        total++; if (pwm_level !== 1'b1) begin bad++; $display("FAIL stuck_level got=%0b want=1", pwm_level); end
        @(negedge clk);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL stuck_pulse_width got=%0b want=0", timeout); end
        gen_period = 8;
        gen_high   = 4;
        ph         = 0;
        gen_on     = 1'b1;
        wait_valid(100, c, r, ok);
        total++; if (!ok || period_meas !== 16'd8 || high_meas !== 16'd4) begin
            bad++; $display("FAIL resume_vals got=%0d/%0d want=8/4", period_meas, high_meas);
        end
    endtask

    task automatic test_enable_abort();
        int c, r, nv, nt;
        bit ok;
        restart(10, 3);
        wait_valid(60, c, r, ok);
        total++; if (!ok || period_meas !== 16'd10 || high_meas !== 16'd3) begin
            bad++; $display("FAIL abort_pre got=%0d/%0d want=10/3", period_meas, high_meas);
        end
        repeat (5) @(negedge clk);
        enable = 1'b0;
        nv = 0;
        nt = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) nv++;
            if (timeout) nt++;
        end
        total++; if (nv != 0 || nt != 0) begin bad++; $display("FAIL abort_pulses got=%0d/%0d want=0/0", nv, nt); end
        total++; if (period_meas !== 16'd10 || high_meas !== 16'd3) begin
            bad++; $display("FAIL abort_retain got=%0d/%0d want=10/3", period_meas, high_meas);
        end
        restart(6, 2);
        wait_valid(60, c, r, ok);
        total++; if (!ok || period_meas !== 16'd6 || high_meas !== 16'd2) begin
            bad++; $display("FAIL reenable_vals got=%0d/%0d want=6/2", period_meas, high_meas);
        end
    endtask

    task automatic test_async_reset();
        int c, r;
        bit ok;
        restart(10, 3);
        wait_valid(60, c, r, ok);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (period_meas !== 16'd0 || high_meas !== 16'd0 || valid !== 1'b0 || pwm_level !== 1'b0) begin
            bad++; $display("FAIL async_reset_outputs got=%0d/%0d/%0b/%0b want=0/0/0/0",
                            period_meas, high_meas, valid, pwm_level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(60, c, r, ok);
        total++; if (!ok || r != 2) begin bad++; $display("FAIL async_reset_rises got=%0d want=2", r); end
        total++; if (period_meas !== 16'd10 || high_meas !== 16'd3) begin
            bad++; $display("FAIL async_reset_vals got=%0d/%0d want=10/3", period_meas, high_meas);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_min_period();
        test_max_and_stuck();
        test_enable_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
